// File: rtl/up_down_counter_nbit.sv
// Multi-channel up/down counter with wrap or saturate limits, per-channel load,
// and an optional cascade where each channel steps only on its predecessor's carry.
module up_down_counter_nbit #(
  parameter int WIDTH       = 10,
  parameter int CHANNELS    = 2,
  parameter int INCREMENT   = 1,
  parameter int MIN_VALUE   = 0,
  parameter int MAX_VALUE   = (2**WIDTH)-1,
  parameter int RESET_VALUE = 0,
  parameter int SATURATE    = 0,
  parameter int CASCADE     = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       countDown,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] loadValue,
  output logic [CHANNELS*WIDTH-1:0] countValue,
  output logic [CHANNELS-1:0]       carryOut,
  output logic [CHANNELS-1:0]       terminalPulse
);

  localparam logic [WIDTH:0]   UP_LIMIT   = (WIDTH+1)'(MAX_VALUE - INCREMENT);
  localparam logic [WIDTH:0]   DOWN_LIMIT = (WIDTH+1)'(MIN_VALUE + INCREMENT);
  localparam logic [WIDTH:0]   MIN_EXT    = (WIDTH+1)'(MIN_VALUE);
  localparam logic [WIDTH:0]   MAX_EXT    = (WIDTH+1)'(MAX_VALUE);
  localparam logic [WIDTH-1:0] MIN_W      = WIDTH'(MIN_VALUE);
  localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] RST_W      = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INCREMENT);

  logic [CHANNELS-1:0] eff_en;
  logic [CHANNELS-1:0] at_bound;
  logic [CHANNELS-1:0] carry_comb;
  logic                ripple;

  // The carry chain lives in one block so the cascade ripples through every
  // channel in a single evaluation; channel 0 always sees an open gate.
  always_comb begin
    eff_en     = '0;
    carry_comb = '0;
    ripple     = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      eff_en[i]     = enable[i] & ((CASCADE == 0) | ripple);
      carry_comb[i] = eff_en[i] & ~load[i] & at_bound[i];
      ripple        = carry_comb[i];
    end
  end

  assign carryOut = carry_comb;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             terminal_reg;
    logic [WIDTH-1:0] load_raw;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   up_diff;
    logic [WIDTH:0]   down_diff;
    logic [WIDTH:0]   low_diff;
    logic [WIDTH:0]   high_diff;

    assign load_raw  = loadValue[gi*WIDTH +: WIDTH];
    assign count_ext = {1'b0, count_reg};

    // Limit tests use the borrow bit of a WIDTH+1 subtraction, so no
    // comparison ever wraps regardless of where the limits sit.
    assign up_diff   = UP_LIMIT - count_ext;
    assign down_diff = count_ext - DOWN_LIMIT;
    assign low_diff  = {1'b0, load_raw} - MIN_EXT;
    assign high_diff = MAX_EXT - {1'b0, load_raw};

    assign at_bound[gi] = countDown[gi] ? down_diff[WIDTH] : up_diff[WIDTH];

    always_comb begin
      load_clamped = load_raw;
      if (low_diff[WIDTH]) begin
        load_clamped = MIN_W;
      end else if (high_diff[WIDTH]) begin
        load_clamped = MAX_W;
      end
    end

    always_comb begin
      count_next = count_reg;
      if (load[gi]) begin
        count_next = load_clamped;
      end else if (eff_en[gi]) begin
        if (!at_bound[gi]) begin
          count_next = countDown[gi] ? (count_reg - INC_W) : (count_reg + INC_W);
        end else if (SATURATE != 0) begin
          count_next = countDown[gi] ? MIN_W : MAX_W;
        end else begin
          count_next = countDown[gi] ? MAX_W : MIN_W;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        count_reg    <= RST_W;
        terminal_reg <= 1'b0;
      end else begin
        count_reg    <= count_next;
        terminal_reg <= carry_comb[gi];
      end
    end

    assign countValue[gi*WIDTH +: WIDTH] = count_reg;
    assign terminalPulse[gi]             = terminal_reg;
  end

endmodule

// File: tb/tb_up_down_counter_nbit.sv
// Bench for up_down_counter_nbit: three instances (wrap, saturate, cascaded clock)
// checked against a behavioural model through an expected-value scoreboard.
module tb_up_down_counter_nbit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [1:0]  a_en, a_dn, a_ld, a_co, a_tp;
  logic [7:0]  a_lv, a_cv;
  logic [1:0]  b_en, b_dn, b_ld, b_co, b_tp;
  logic [7:0]  b_lv, b_cv;
  logic [1:0]  c_en, c_dn, c_ld, c_co, c_tp;
  logic [11:0] c_lv, c_cv;

  up_down_counter_nbit #(.WIDTH(4)) dut_a (
    .clock(clock), .reset(reset), .enable(a_en), .countDown(a_dn), .load(a_ld),
    .loadValue(a_lv), .countValue(a_cv), .carryOut(a_co), .terminalPulse(a_tp));

  up_down_counter_nbit #(.WIDTH(4), .INCREMENT(3), .SATURATE(1), .RESET_VALUE(5)) dut_b (
    .clock(clock), .reset(reset), .enable(b_en), .countDown(b_dn), .load(b_ld),
    .loadValue(b_lv), .countValue(b_cv), .carryOut(b_co), .terminalPulse(b_tp));

  up_down_counter_nbit #(.WIDTH(6), .MAX_VALUE(59), .CASCADE(1)) dut_c (
    .clock(clock), .reset(reset), .enable(c_en), .countDown(c_dn), .load(c_ld),
    .loadValue(c_lv), .countValue(c_cv), .carryOut(c_co), .terminalPulse(c_tp));

  // Per-instance parameters as seen by the model.
  int p_min [3] = '{0, 0, 0};
  int p_max [3] = '{15, 15, 59};
  int p_inc [3] = '{1, 3, 1};
  int p_sat [3] = '{0, 1, 0};
  int p_cas [3] = '{0, 0, 1};
  int p_rst [3] = '{0, 5, 0};

  int m_cnt [3][2];

  typedef struct {
    int dut;
    int ch;
    int kind;   // 0 count, 1 carry, 2 terminal pulse
    int exp;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];

  int n_compared = 0;
  int n_mismatch = 0;
  int cycle      = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int observe(input int d, input int ch, input int kind);
    int r;
    r = 0;
    case (d)
      0: case (kind)
           0: r = int'(a_cv[ch*4 +: 4]);
           1: r = int'(a_co[ch]);
           default: r = int'(a_tp[ch]);
         endcase
      1: case (kind)
           0: r = int'(b_cv[ch*4 +: 4]);
           1: r = int'(b_co[ch]);
           default: r = int'(b_tp[ch]);
         endcase
      default: case (kind)
           0: r = int'(c_cv[ch*6 +: 6]);
           1: r = int'(c_co[ch]);
           default: r = int'(c_tp[ch]);
         endcase
    endcase
    return r;
  endfunction

  // Model one clock of instance d from the inputs currently driven.
  task automatic model_push(input int d);
    logic [1:0] en, dn, ld;
    int lv [2];
    int prev, c, nxt;
    bit eff, atb, carry;
    exp_t e;
    case (d)
      0: begin en = a_en; dn = a_dn; ld = a_ld; lv[0] = int'(a_lv[3:0]); lv[1] = int'(a_lv[7:4]); end
      1: begin en = b_en; dn = b_dn; ld = b_ld; lv[0] = int'(b_lv[3:0]); lv[1] = int'(b_lv[7:4]); end
      default: begin en = c_en; dn = c_dn; ld = c_ld; lv[0] = int'(c_lv[5:0]); lv[1] = int'(c_lv[11:6]); end
    endcase
    prev = 0;
    for (int ch = 0; ch < 2; ch++) begin
      c     = m_cnt[d][ch];
      eff   = en[ch] && (ch == 0 || p_cas[d] == 0 || prev == 1);
      atb   = dn[ch] ? (c < p_min[d] + p_inc[d]) : (c > p_max[d] - p_inc[d]);
      carry = eff && !ld[ch] && atb;
      if (reset)          nxt = p_rst[d];
      else if (ld[ch])    nxt = (lv[ch] < p_min[d]) ? p_min[d] : (lv[ch] > p_max[d]) ? p_max[d] : lv[ch];
      else if (!eff)      nxt = c;
      else if (!atb)      nxt = dn[ch] ? c - p_inc[d] : c + p_inc[d];
      else if (p_sat[d] != 0) nxt = dn[ch] ? p_min[d] : p_max[d];
      else                nxt = dn[ch] ? p_max[d] : p_min[d];
      m_cnt[d][ch] = nxt;
      e.dut = d; e.ch = ch;
      e.kind = 1; e.exp = int'(carry);            comb_q.push_back(e);
      e.kind = 0; e.exp = nxt;                    reg_q.push_back(e);
      e.kind = 2; e.exp = reset ? 0 : int'(carry); reg_q.push_back(e);
      prev = int'(carry);
    end
  endtask

  task automatic step(input string what);
    exp_t e;
    string kname;
    #1;
    for (int d = 0; d < 3; d++) model_push(d);
    while (comb_q.size() > 0) begin
      e = comb_q.pop_front();
      check($sformatf("%s dut%0d ch%0d carry", what, e.dut, e.ch), observe(e.dut, e.ch, 1), e.exp);
    end
    @(posedge clock);
    #1;
    while (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      kname = (e.kind == 0) ? "count" : "tpulse";
      check($sformatf("%s dut%0d ch%0d %s", what, e.dut, e.ch, kname), observe(e.dut, e.ch, e.kind), e.exp);
    end
    cycle++;
    $display("[%0d] %s a=%h/%b b=%h/%b c=%h/%b", cycle, what, a_cv, a_tp, b_cv, b_tp, c_cv, c_tp);
  endtask

  function automatic logic [1:0] rnd_ld();
    return {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
  endfunction

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_cnt[d][0] = 0;
      m_cnt[d][1] = 0;
    end
    reset = 1'b1;
    a_en = '0; a_dn = '0; a_ld = '0; a_lv = '0;
    b_en = '0; b_dn = '0; b_ld = '0; b_lv = '0;
    c_en = '0; c_dn = '0; c_ld = '0; c_lv = '0;

    step("reset");
    step("reset");
    check("reset A ch0", observe(0, 0, 0), 0);
    check("reset A ch1", observe(0, 1, 0), 0);
    check("reset B ch0", observe(1, 0, 0), 5);
    check("reset tp A", int'(a_tp), 0);

    // Wrap: 16 enabled cycles take ch0 from 0 through 15 back to 0.
    reset = 1'b0;
    a_en  = 2'b01;
    repeat (15) step("wrap");
    check("wrap at 15", observe(0, 0, 0), 15);
    step("wrap");
    check("wrap to 0", observe(0, 0, 0), 0);
    check("wrap tpulse", observe(0, 0, 2), 1);

    // Direction flip at the upper limit, and load beating enable.
    a_en = 2'b01; a_ld = 2'b01; a_lv = 8'h0F;
    step("load+en");
    check("load wins", observe(0, 0, 0), 15);
    a_ld = 2'b00; a_dn = 2'b01;
    step("flip down");
    check("flip down", observe(0, 0, 0), 14);
    a_ld = 2'b01; a_en = 2'b00;
    step("reload 15");
    a_ld = 2'b00; a_en = 2'b01; a_dn = 2'b00;
    step("flip up");
    check("flip up wraps", observe(0, 0, 0), 0);
    a_en = 2'b00;

    // Saturating down count by 3, then saturating up on ch1.
    b_ld = 2'b01; b_lv = 8'h07;
    step("sat load");
    b_ld = 2'b00; b_en = 2'b01; b_dn = 2'b01;
    step("sat dn"); check("sat 4", observe(1, 0, 0), 4);
    step("sat dn"); check("sat 1", observe(1, 0, 0), 1);
    step("sat dn"); check("sat 0", observe(1, 0, 0), 0);
    step("sat dn"); check("sat hold", observe(1, 0, 0), 0);
    b_en = 2'b00; b_ld = 2'b10; b_lv = 8'hD0;
    step("sat load up");
    b_ld = 2'b00; b_en = 2'b10; b_dn = 2'b00;
    step("sat up"); check("sat up 15", observe(1, 1, 0), 15);
    step("sat up"); check("sat up hold", observe(1, 1, 0), 15);
    b_en = 2'b00;

    // Chess clock: minutes:seconds counting down through the cascade.
    c_ld = 2'b11; c_lv = {6'd2, 6'd0};
    step("clock load");
    c_ld = 2'b00; c_en = 2'b11; c_dn = 2'b11;
    step("clock tick");
    check("clock min 1", observe(2, 1, 0), 1);
    check("clock sec 59", observe(2, 0, 0), 59);
    repeat (60) step("clock tick");
    check("clock min 0", observe(2, 1, 0), 0);
    check("clock sec 59b", observe(2, 0, 0), 59);

    // Clamp on load above MAX_VALUE.
    c_en = 2'b01; c_ld = 2'b01; c_lv = {6'd0, 6'd63};
    step("clamp");
    check("clamp 59", observe(2, 0, 0), 59);

    // Reset on the very edge where ch0 carries into ch1.
    c_en = 2'b00; c_ld = 2'b11; c_lv = {6'd5, 6'd0};
    step("pre-reset load");
    c_ld = 2'b00; c_en = 2'b11; c_dn = 2'b11; reset = 1'b1;
    step("reset cascade");
    check("rst cas ch0", observe(2, 0, 0), 0);
    check("rst cas ch1", observe(2, 1, 0), 0);
    reset = 1'b0; c_en = 2'b00;
    step("post reset");
    check("rst cas tpulse", int'(c_tp), 0);

    // Randomised traffic on all instances.
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      a_en = 2'($urandom); a_dn = 2'($urandom); a_ld = rnd_ld(); a_lv = 8'($urandom);
      b_en = 2'($urandom); b_dn = 2'($urandom); b_ld = rnd_ld(); b_lv = 8'($urandom);
      c_en = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      c_dn = 2'($urandom); c_ld = rnd_ld(); c_lv = 12'($urandom);
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/up_down_counter_nbit.md
# up_down_counter_nbit

Multi-channel, parametrised up/down counter: the successor to the single-channel up-counter used across the game's timing logic. Each channel has its own enable, direction and synchronous load, and can either wrap or saturate at its limits. An optional cascade mode chains channels so that channel i counts only on channel i-1's boundary carry. This lets one instance form a seconds/minutes player clock that counts down to flag-fall.

## Interface
Parameters:
- WIDTH, 10, bits per channel count.
- CHANNELS, 2, number of independent counter channels (≥1).
- INCREMENT, 1, step per enabled cycle; legal range 1..(MAX_VALUE-MIN_VALUE).
- MIN_VALUE, 0, lower count limit.
- MAX_VALUE, (2**WIDTH)-1, upper count limit; MIN_VALUE < MAX_VALUE ≤ 2**WIDTH-1.
- RESET_VALUE, 0, count loaded on reset; must satisfy MIN_VALUE ≤ RESET_VALUE ≤ MAX_VALUE.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.
- CASCADE, 0, 1 = channel i>0 is gated by channel i-1 carry.

Ports:
- clock  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  CHANNELS  per-channel count enable.
- countDown  input  CHANNELS  per-channel direction: 1 = decrement, 0 = increment.
- load  input  CHANNELS  per-channel synchronous load strobe.
- loadValue  input  CHANNELS*WIDTH  load data; channel i occupies bits [i*WIDTH +: WIDTH].
- countValue  output  CHANNELS*WIDTH  registered counts, packed the same way.
- carryOut  output  CHANNELS  combinational: channel steps across its boundary this cycle.
- terminalPulse  output  CHANNELS  registered copy of carryOut, one cycle late.

## Operation
- Effective enable:
  - effEn[0] = enable[0].
  - For i>0: effEn[i] = enable[i] & (CASCADE ? carryOut[i-1] : 1).
- Up boundary: count > MAX_VALUE-INCREMENT. Down boundary: count < MIN_VALUE+INCREMENT.
  - Evaluate boundaries in WIDTH+1-bit arithmetic so neither underflows nor overflows.
- carryOut[i] = effEn[i] & ~load[i] & (boundary for the current direction).
- Per-channel priority each rising edge:
  1. reset: count = RESET_VALUE.
  2. load: count = loadValue clamped to [MIN_VALUE, MAX_VALUE].
  3. effEn, not at boundary: count ± INCREMENT.
  4. effEn, at boundary, SATURATE=0: up wraps to MIN_VALUE, down wraps to MAX_VALUE. There is no remainder carry-over.
  5. effEn, at boundary, SATURATE=1: count moves to MAX_VALUE (up) or MIN_VALUE (down) and then holds.
  6. Otherwise: hold.
- In saturate mode, carryOut stays asserted on every enabled cycle while the channel sits at its limit. This gives continuous flag-fall indication.
- A load on channel i-1 suppresses its carry, so a cascaded channel i does not step in that cycle.
- Direction may change on any cycle. The new direction applies to the current edge.
- If countValue leaves [MIN, MAX] (only possible via illegal parameters), the boundary rules still apply. An up count therefore wraps or saturates on the next enabled cycle.

## Timing
- Reset values:
  - countValue = RESET_VALUE on every channel.
  - terminalPulse = 0.
  - carryOut follows its combinational definition. It is 0 while all enables are low.
- Latency:
  - countValue updates one cycle after enable/load is sampled.
  - carryOut is same-cycle.
  - terminalPulse follows one cycle after carryOut.
- Cascade ripple is combinational across all CHANNELS within one cycle. A full rollover of every channel completes on a single edge.
- Reset during a cascade clears all channels on the same edge. terminalPulse goes 0 on that edge with no residual pulse.
- load and enable together on one channel: load wins. carryOut for that channel is 0.

## Test plan
- Reset/wrap, defaults with WIDTH=4, MAX=15:
  - Hold reset 2 cycles -> countValue=0 on both channels.
  - Enable ch0 for 16 cycles -> count 1..15, then 0.
  - carryOut[0] high on the cycle count=15; terminalPulse[0] high the next cycle.
- Down saturate, SATURATE=1, MIN=0, INCREMENT=3:
  - Load 7 then count down -> 4, 1, 0, 0.
  - carryOut high on the cycles at 1 and at 0 while enabled.
- Chess clock, CASCADE=1, WIDTH=6, MIN=0, MAX=59, both channels counting down:
  - Load ch1=2, ch0=0 with enable=2'b11 -> next edge gives ch1=1, ch0=59.
  - After 60 more cycles -> ch1=0, ch0=59.
- Load priority and clamp, MAX=9:
  - load=1, enable=1, loadValue=12 -> count=9; carryOut=0 that cycle.
- Direction flip at limit, wrap mode, MAX=15:
  - At count=15 set countDown=1 -> 14, no carry.
  - Set countDown=0 at 15 -> 0 with carry.
- Reset mid-cascade:
  - Assert reset on the cycle ch0 carries into ch1 -> both channels = RESET_VALUE.
  - terminalPulse stays 0 on the following cycle.
